// File: rtl/snes_controller_emulator.sv
`default_nettype none
// ============================================================================
// Module   : snes_controller_emulator
// Brief    : Device-side SNES pad emulator; snapshots a button word on the host
//            latch and shifts it out MSB first on each pad-clock rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module snes_controller_emulator #(
  parameter int NBITS    = 16,
  parameter bit INVERT   = 1'b0,
  parameter bit IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_latch,
  input  logic             pad_clk,
  input  logic [NBITS-1:0] buttons,
  output logic             pad_data,
  output logic             busy,
  output logic             frame_done
);

  localparam int             CW        = $clog2(NBITS) + 1;
  localparam logic [CW-1:0]  c_last    = CW'(NBITS - 1);
  localparam logic           c_idle_lv = IDLE_BIT ^ INVERT;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_latch = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [2:0]       r_lat_sync;
  logic [2:0]       r_clk_sync;
  logic [1:0]       r_state;
  logic [NBITS-1:0] r_shreg;
  logic [CW-1:0]    r_count;

  logic             w_lat_rise;
  logic             w_lat_high;
  logic             w_clk_rise;
  logic [1:0]       w_state_n;
  logic [NBITS-1:0] w_shreg_n;
  logic [CW-1:0]    w_count_n;
  logic             w_done_n;
  logic             w_drive_n;

  // Bits [1:0] are the metastability pair; bit 2 holds the previous value for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_sync <= 3'b000;
      r_clk_sync <= 3'b000;
    end else begin
      r_lat_sync <= {r_lat_sync[1:0], pad_latch};
      r_clk_sync <= {r_clk_sync[1:0], pad_clk};
    end
  end

  assign w_lat_high = r_lat_sync[1];
  assign w_lat_rise = r_lat_sync[1] & ~r_lat_sync[2];
  assign w_clk_rise = r_clk_sync[1] & ~r_clk_sync[2];

  // A latch edge has priority over everything, including a coincident clock edge.
  always_comb begin
    w_state_n = r_state;
    w_shreg_n = r_shreg;
    w_count_n = r_count;
    w_done_n  = 1'b0;
    if (w_lat_rise) begin
      w_shreg_n = buttons;
      w_count_n = '0;
      w_state_n = c_st_latch;
    end else begin
      case (r_state)
        c_st_latch: begin
          if (w_lat_high) begin
            w_shreg_n = buttons;
          end else begin
            w_state_n = c_st_shift;
          end
        end
        c_st_shift: begin
          if (w_clk_rise) begin
            w_shreg_n = {r_shreg[NBITS-2:0], IDLE_BIT};
            w_count_n = r_count + CW'(1);
            if (r_count == c_last) begin
              w_state_n = c_st_done;
              w_done_n  = 1'b1;
            end
          end
        end
        default: begin
          w_state_n = r_state;
        end
      endcase
    end
  end

  assign w_drive_n = (w_state_n == c_st_latch) || (w_state_n == c_st_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_shreg    <= '0;
      r_count    <= '0;
      pad_data   <= c_idle_lv;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_shreg    <= w_shreg_n;
      r_count    <= w_count_n;
      pad_data   <= w_drive_n ? (w_shreg_n[NBITS-1] ^ INVERT) : c_idle_lv;
      frame_done <= w_done_n;
    end
  end

  assign busy = (r_state == c_st_latch) || (r_state == c_st_shift);

endmodule
`default_nettype wire

// File: tb/tb_snes_controller_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_snes_controller_emulator
// Brief    : Directed, table-driven bench for snes_controller_emulator (raw and
//            inverted instances driven from the same host lines).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snes_controller_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pad_latch;
  logic        pad_clk;
  logic [15:0] buttons;
  logic        pad_data,   busy,   frame_done;
  logic        pad_data_i, busy_i, frame_done_i;

  int n_checks = 0;
  int n_fail   = 0;
  int done_total   = 0;
  int done_total_i = 0;

  always #5 clk = ~clk;

  snes_controller_emulator #(.NBITS(16), .INVERT(1'b0), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .buttons(buttons), .pad_data(pad_data), .busy(busy), .frame_done(frame_done)
  );

  snes_controller_emulator #(.NBITS(16), .INVERT(1'b1), .IDLE_BIT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .buttons(buttons), .pad_data(pad_data_i), .busy(busy_i), .frame_done(frame_done_i)
  );

  always @(negedge clk) begin
    if (frame_done)   done_total   <= done_total + 1;
    if (frame_done_i) done_total_i <= done_total_i + 1;
  end

  typedef struct {
    logic [15:0] b_start;
    logic [15:0] b_frame;
    int          nclk;
    int          change_at;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host-style clocking: pad_clk idles high, sample while low, device shifts on the rise.
  task automatic clock_bits(input logic [15:0] b, input int nclk, input int change_at,
                            input string tag);
    logic [15:0] inv_got;
    logic [15:0] inv_exp;
    logic        exp_bit;
    int          d0, di0;
    inv_got = '0;
    inv_exp = ~b;
    d0  = done_total;
    di0 = done_total_i;
    for (int k = 0; k < nclk; k++) begin
      if (k == change_at) buttons = ~buttons;
      pad_clk = 1'b0;
      wait_cyc(8);
      exp_bit = (k < 16) ? b[15-k] : 1'b1;
      check($sformatf("%s bit%0d", tag, k), {31'd0, pad_data}, {31'd0, exp_bit});
      if (k < 16) inv_got[15-k] = pad_data_i;
      pad_clk = 1'b1;
      wait_cyc(8);
    end
    if (nclk >= 16) begin
      check({tag, " inv word"}, {16'd0, inv_got}, {16'd0, inv_exp});
      check({tag, " idle"},     {31'd0, pad_data},   32'd1);
      check({tag, " inv idle"}, {31'd0, pad_data_i}, 32'd0);
    end
    check({tag, " done cnt"},   done_total - d0,    (nclk >= 16) ? 32'd1 : 32'd0);
    check({tag, " inv done"},   done_total_i - di0, (nclk >= 16) ? 32'd1 : 32'd0);
    check({tag, " busy after"}, {31'd0, busy},      (nclk < 16) ? 32'd1 : 32'd0);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    buttons   = v.b_start;
    pad_latch = 1'b1;
    wait_cyc(6);
    buttons = v.b_frame;
    wait_cyc(6);
    check({tag, " busy latch"}, {31'd0, busy}, 32'd1);
    pad_latch = 1'b0;
    wait_cyc(8);
    clock_bits(v.b_frame, v.nclk, v.change_at, tag);
  endtask

  initial begin
    vec_t v;
    int   d0;

    tbl[0] = '{16'hA5C3, 16'hA5C3, 16, -1};
    tbl[1] = '{16'h0001, 16'h0001, 16, -1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 20, -1};
    tbl[3] = '{16'h1111, 16'hF00F, 16, -1};
    tbl[4] = '{16'hA5C3, 16'hA5C3, 17,  5};
    tbl[5] = '{16'h0000, 16'h0000, 16, -1};

    rst_n = 1'b0; pad_latch = 1'b0; pad_clk = 1'b1; buttons = 16'hA5C3;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(4);
      pad_latch = ~pad_latch;
      pad_clk   = ~pad_clk;
      wait_cyc(4);
      check($sformatf("reset data %0d", i), {31'd0, pad_data},   32'd1);
      check($sformatf("reset inv %0d", i),  {31'd0, pad_data_i}, 32'd0);
      check($sformatf("reset busy %0d", i), {31'd0, busy},       32'd0);
      check($sformatf("reset done %0d", i), {31'd0, frame_done}, 32'd0);
    end
    check("reset no pulses", done_total, 32'd0);
    pad_latch = 1'b0; pad_clk = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(8);
    check("idle busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Abort mid-frame and re-latch with a new word.
    v = '{16'h1234, 16'h1234, 7, -1};
    run_frame(v, "abort pre");
    v = '{16'h8001, 16'h8001, 16, -1};
    run_frame(v, "abort post");

    // Latch and pad-clock rise in the same cycle, while mid-SHIFT.
    v = '{16'hA5C3, 16'hA5C3, 3, -1};
    run_frame(v, "coll pre");
    pad_clk = 1'b0;
    wait_cyc(8);
    buttons   = 16'hDA3C;
    pad_latch = 1'b1;
    pad_clk   = 1'b1;
    wait_cyc(6);
    check("coll busy", {31'd0, busy},     32'd1);
    check("coll msb",  {31'd0, pad_data}, 32'd1);
    wait_cyc(4);
    pad_latch = 1'b0;
    wait_cyc(8);
    clock_bits(16'hDA3C, 16, -1, "coll post");

    // Reset mid-frame: immediate return to idle, no frame without a new latch.
    v = '{16'h0F0F, 16'h0F0F, 5, -1};
    run_frame(v, "rst pre");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst async data", {31'd0, pad_data}, 32'd1);
    check("rst async busy", {31'd0, busy},     32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);
    d0 = done_total;
    for (int k = 0; k < 4; k++) begin
      pad_clk = 1'b0;
      wait_cyc(8);
      check($sformatf("rst post bit%0d", k), {31'd0, pad_data}, 32'd1);
      pad_clk = 1'b1;
      wait_cyc(8);
    end
    check("rst post busy", {31'd0, busy}, 32'd0);
    check("rst post done", done_total - d0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
